// File: rtl/rubik_wrdma_fifo_pkg.sv
// rtl/rubik_wrdma_fifo_pkg.sv - shared widths and depth for the Rubik write-request FIFOs
package rubik_wrdma_fifo_pkg;

    // Payload width of the DMA write-command queue instance
    localparam int unsigned RUBIK_WRDMA_CMD_W  = 73;
    // Payload width of each write-data half queue instance
    localparam int unsigned RUBIK_WRDMA_DATA_W = 256;
    // Entries per queue; must be a power of two and at least 2
    localparam int unsigned RUBIK_WRDMA_DEPTH  = 8;

endpackage

// File: rtl/rubik_wrdma_fifo_ram.sv
// rtl/rubik_wrdma_fifo_ram.sv - flop-based storage array with one write and one async read port
module rubik_wrdma_fifo_ram
    import rubik_wrdma_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = RUBIK_WRDMA_DATA_W,
    parameter int unsigned DEPTH = RUBIK_WRDMA_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic [31:0]      pwrbus_ram_pd
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Power-down control has no functional effect on a flop array; fold it into a sink net
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    // Storage is intentionally not reset: contents are only meaningful behind valid pointers
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rubik_wrdma_fifo.sv
// rtl/rubik_wrdma_fifo.sv - first-word-fall-through valid/ready FIFO with registered ready
module rubik_wrdma_fifo
    import rubik_wrdma_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = RUBIK_WRDMA_DATA_W,
    parameter int unsigned DEPTH = RUBIK_WRDMA_DEPTH
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             idata_pvld,
    output logic             idata_prdy,
    input  logic [WIDTH-1:0] idata_pd,
    output logic             odata_pvld,
    input  logic             odata_prdy,
    output logic [WIDTH-1:0] odata_pd,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push;
    logic          pop;

    // Ready and valid come straight from the registered count, so odata_prdy never reaches idata_prdy
    assign idata_prdy = (count_q != FULL_CNT);
    assign odata_pvld = (count_q != '0);

    assign push = idata_pvld & idata_prdy;
    assign pop  = odata_pvld & odata_prdy;

    // Next-state pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and count state; reset discards all contents immediately
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    rubik_wrdma_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk           (nvdla_core_clk),
        .we            (push),
        .waddr         (wr_ptr_q),
        .wdata         (idata_pd),
        .raddr         (rd_ptr_q),
        .rdata         (odata_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

endmodule

// File: tb/tb_rubik_wrdma_fifo.sv
// tb/tb_rubik_wrdma_fifo.sv - self-checking bench for rubik_wrdma_fifo against a queue model
module tb_rubik_wrdma_fifo;

    localparam int W = 256;
    localparam int D = 8;

    logic         clk;
    logic         rst;
    logic         idata_pvld;
    logic         idata_prdy;
    logic [W-1:0] idata_pd;
    logic         odata_pvld;
    logic         odata_prdy;
    logic [W-1:0] odata_pd;
    logic [31:0]  pwrbus_ram_pd;

    logic [W-1:0] mq[$];
    int           vectors;
    int           miscompares;

    rubik_wrdma_fifo #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .idata_pvld     (idata_pvld),
        .idata_prdy     (idata_prdy),
        .idata_pd       (idata_pd),
        .odata_pvld     (odata_pvld),
        .odata_prdy     (odata_prdy),
        .odata_pd       (odata_pd),
        .pwrbus_ram_pd  (pwrbus_ram_pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: apply inputs, let the edge happen, apply the queue rules, return at the next negedge.
    task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic r);
        logic do_push, do_pop;
        idata_pvld    = v;
        idata_pd      = d;
        odata_prdy    = r;
        pwrbus_ram_pd = $urandom;
        do_push = v && (mq.size() < D);
        do_pop  = r && (mq.size() > 0);
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(d);
        @(negedge clk);
        idata_pvld = 1'b0;
        odata_prdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idata_pvld = 1'b0;
        odata_prdy = 1'b0;
        idata_pd = '0;
        pwrbus_ram_pd = '0;
        mq.delete();
        #1;
        vectors++;
        if (odata_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pvld: got %b expected 0", odata_pvld);
        end
        vectors++;
        if (idata_prdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_prdy: got %b expected 1", idata_prdy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_push();
        idata_pvld = 1'b1;
        idata_pd   = W'(1);
        #1;
        vectors++;
        if (odata_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL first_push_no_bypass: got %b expected 0", odata_pvld);
        end
        drive_cycle(1'b1, W'(1), 1'b0);
        vectors++;
        if (odata_pvld !== 1'b1 || odata_pd !== W'(1)) begin
            miscompares++;
            $display("FAIL first_push_visible: got pvld=%b pd=%h expected pvld=1 pd=1", odata_pvld, odata_pd);
        end
        vectors++;
        if (idata_prdy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_push_prdy: got %b expected 1", idata_prdy);
        end
        drive_cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < D; i++) drive_cycle(1'b1, W'(i), 1'b0);
        vectors++;
        if (idata_prdy !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full_prdy: got %b expected 0", idata_prdy);
        end
        drive_cycle(1'b1, W'(32'h99), 1'b0);
        for (int i = 0; i < D; i++) begin
            vectors++;
            if (odata_pvld !== 1'b1 || odata_pd !== W'(i)) begin
                miscompares++;
                $display("FAIL fill_drain_order: got pvld=%b pd=%h expected pvld=1 pd=%h", odata_pvld, odata_pd, W'(i));
            end
            drive_cycle(1'b0, '0, 1'b1);
        end
        vectors++;
        if (odata_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_drain_empty: got %b expected 0", odata_pvld);
        end
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < D; i++) drive_cycle(1'b1, W'(32'h100 + i), 1'b0);
        drive_cycle(1'b1, W'(32'h1FF), 1'b1);
        vectors++;
        if (idata_prdy !== 1'b1 || odata_pd !== W'(32'h101)) begin
            miscompares++;
            $display("FAIL full_pop_only: got prdy=%b pd=%h expected prdy=1 pd=101", idata_prdy, odata_pd);
        end
        drive_cycle(1'b1, W'(32'h1FF), 1'b0);
        vectors++;
        if (idata_prdy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_refill: got prdy=%b expected 0", idata_prdy);
        end
        for (int i = 1; i <= D; i++) begin
            logic [W-1:0] exp_v;
            exp_v = (i < D) ? W'(32'h100 + i) : W'(32'h1FF);
            vectors++;
            if (odata_pvld !== 1'b1 || odata_pd !== exp_v) begin
                miscompares++;
                $display("FAIL full_pop_push_order: got pd=%h expected %h", odata_pd, exp_v);
            end
            drive_cycle(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_stream();
        drive_cycle(1'b1, W'(32'h10), 1'b0);
        for (int i = 1; i < 20; i++) begin
            drive_cycle(1'b1, W'(32'h10 + i), 1'b1);
            vectors++;
            if (odata_pvld !== 1'b1 || odata_pd !== W'(32'h10 + i) || idata_prdy !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_wrap: got pvld=%b pd=%h expected pvld=1 pd=%h", odata_pvld, odata_pd, W'(32'h10 + i));
            end
        end
        drive_cycle(1'b0, '0, 1'b1);
        vectors++;
        if (odata_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end_empty: got %b expected 0", odata_pvld);
        end
    endtask

    task automatic test_backpressure();
        drive_cycle(1'b1, W'(32'hABCD), 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, rand_word(), 1'b0);
            vectors++;
            if (odata_pvld !== 1'b1 || odata_pd !== W'(32'hABCD)) begin
                miscompares++;
                $display("FAIL backpressure_hold: got pvld=%b pd=%h expected pvld=1 pd=abcd", odata_pvld, odata_pd);
            end
        end
        drive_cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, rand_word(), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (odata_pvld !== 1'b0 || idata_prdy !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got pvld=%b prdy=%b expected pvld=0 prdy=1", odata_pvld, idata_prdy);
        end
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, W'(32'h77), 1'b0);
        vectors++;
        if (odata_pvld !== 1'b1 || odata_pd !== W'(32'h77)) begin
            miscompares++;
            $display("FAIL async_reset_first: got pvld=%b pd=%h expected pvld=1 pd=77", odata_pvld, odata_pd);
        end
        drive_cycle(1'b0, '0, 1'b1);
        vectors++;
        if (odata_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_alone: got %b expected 0", odata_pvld);
        end
    endtask

    task automatic test_random();
        int pv, pr;
        for (int n = 0; n < 600; n++) begin
            if (n % 100 == 0) begin
                pv = $urandom_range(20, 90);
                pr = $urandom_range(20, 90);
            end
            vectors++;
            if (odata_pvld !== (mq.size() != 0) || idata_prdy !== (mq.size() != D)) begin
                miscompares++;
                $display("FAIL random_flags: got pvld=%b prdy=%b expected occupancy %0d", odata_pvld, idata_prdy, mq.size());
            end
            if (mq.size() != 0) begin
                vectors++;
                if (odata_pd !== mq[0]) begin
                    miscompares++;
                    $display("FAIL random_head: got %h expected %h", odata_pd, mq[0]);
                end
            end
            drive_cycle($urandom_range(0, 99) < pv, rand_word(), $urandom_range(0, 99) < pr);
        end
        while (mq.size() != 0) drive_cycle(1'b0, '0, 1'b1);
        vectors++;
        if (odata_pvld !== 1'b0) begin
            miscompares++;
            $display("FAIL random_drain: got %b expected 0", odata_pvld);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_first_push();
        test_fill_drain();
        test_full_pop_push();
        test_stream();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
